// File: rtl/ifu_ibuf.sv
// Instruction buffer between fetch response and EXE: small FIFO of {pc, instr, fault}
// with flush-to-empty and a halt-on-misaligned-fetch intake lock.
module ifu_ibuf #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          exe_flush,
   input  logic          int_flush,
   input  logic          in_valid,
   input  logic [31:0]   in_pc,
   input  logic [31:0]   in_instr,
   input  logic          in_misalign,
   output logic          in_rdy,
   output logic          out_valid,
   output logic [31:0]   out_pc,
   output logic [31:0]   out_instr,
   output logic          out_fault,
   input  logic          out_ready,
   output logic [AW:0]   count
);

   typedef enum logic {RUN, HALT} state_t;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic [31:0]      pc_mem    [DEPTH];
   logic [31:0]      instr_mem [DEPTH];
   logic [DEPTH-1:0] fault_mem;

   state_t        state, state_nx;
   logic [AW-1:0] wp, rp;
   logic          flush, push, pop;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      flush     = exe_flush | int_flush;
      in_rdy    = (count != FULL) && (state == RUN) && !flush;
      out_valid = (count != '0) && !flush;
      push      = in_valid & in_rdy;
      pop       = out_valid & out_ready;
      state_nx  = state;
      if (flush)
         state_nx = RUN;
      else if (push && in_misalign)
         state_nx = HALT;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         state <= state_nx;
         if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
         end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            if (push && !pop)
               count <= count + 1'b1;
            else if (pop && !push)
               count <= count - 1'b1;
         end
      end
   end

   // Fault bits are reset so out_fault reads 0 out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fault_mem <= '0;
      else if (push)
         fault_mem[wp] <= in_misalign;
   end

   // NOTE: the data array has no reset; out_valid qualifies it, so reset flops would be wasted.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wp]    <= in_pc;
         instr_mem[wp] <= in_misalign ? NOP : in_instr;
      end
   end

   assign out_pc    = pc_mem[rp];
   assign out_instr = instr_mem[rp];
   assign out_fault = fault_mem[rp];

endmodule

// File: doc/ifu_ibuf.md
# ifu_ibuf

Instruction buffer between the instruction-fetch response path and the execute stage. It queues fetched {PC, instruction} pairs in a small FIFO and presents the oldest to EXE with a valid/ready handshake. It returns a registered-full-derived ready to the PC generator. It discards all content on an execute or interrupt flush, and turns a misaligned fetch into a single tagged fault entry that halts further intake until the next flush.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- AW, 2, log2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- exe_flush  in  1  branch/jump redirect from EXE
- int_flush  in  1  interrupt/exception redirect
- in_valid  in  1  fetched entry offered (already gated by flush upstream)
- in_pc  in  32  PC of offered entry
- in_instr  in  32  instruction word
- in_misalign  in  1  offered PC has PC[1:0]≠0
- in_rdy  out  1  buffer accepts an entry this cycle
- out_valid  out  1  head entry valid to EXE
- out_pc  out  32  head PC
- out_instr  out  32  head instruction
- out_fault  out  1  head entry is a misaligned-fetch fault
- out_ready  in  1  EXE consumes head this cycle
- count  out  AW+1  occupied entries

## Operation
- Storage: DEPTH entries of {pc[31:0], instr[31:0], fault}. Write pointer wp and read pointer rp are AW bits wide and wrap modulo DEPTH. count ranges 0..DEPTH.
- Push: in_valid & in_rdy. The entry is written at wp and wp increments. If in_misalign, the entry is stored with fault=1 and instr=32'h0000_0013 (NOP).
- Pop: out_valid & out_ready. rp increments.
- count update: count+1 on push only, count−1 on pop only, unchanged on push & pop.
- in_rdy = (count != DEPTH) & (state == RUN) & ~exe_flush & ~int_flush. There is no bypass when full: a pop in the same cycle does not free a slot until the next cycle.
- out_valid = (count != 0) & ~exe_flush & ~int_flush. out_pc, out_instr and out_fault come combinationally from entry rp.
- State machine (2 states):
  - RUN: normal operation. A push with in_misalign moves to HALT.
  - HALT: in_rdy is 0. Already-queued entries, including the fault entry, still drain to EXE. exe_flush | int_flush moves to RUN.
- Flush (exe_flush | int_flush high in a cycle):
  - The next edge sets wp=rp=0, count=0, state=RUN.
  - Any push or pop attempted in that cycle is ignored.
  - Storage contents are not cleared.

## Timing
- Reset values: count=0, wp=rp=0, state=RUN. Outputs: out_valid=0, out_fault=0, in_rdy=1, out_pc and out_instr are don't-care (storage is not reset).
- Latency: an entry pushed at edge N is presented with out_valid=1 in the cycle after edge N. Minimum in-to-out latency is 1 cycle.
- Throughput: one push and one pop per cycle, sustained at any count between 1 and DEPTH−1.
- Full (count==DEPTH): in_rdy=0 even if out_ready=1 in that cycle.
- Empty (count==0): out_valid=0 and out_ready is ignored.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no gap or bubble.
- Flush takes priority over push, pop and HALT. A flush and a misaligned push in the same cycle leave the block in RUN with count=0.
- Reset asserted mid-operation returns every register to its reset value immediately, without waiting for a clock edge.

## Test plan
- Reset, then push PCs 0x00,0x04,0x08,0x0C with out_ready=0 → count=4, in_rdy=0. Then set out_ready=1 → out_pc returns 0x00,0x04,0x08,0x0C on consecutive cycles, then count=0 and out_valid=0.
- Continuous push and pop of 10 entries with out_ready=1 → count stays at 1, out_pc equals in_pc delayed 1 cycle, pointers wrap twice, no bubbles.
- With count=4 (full), assert in_valid with in_pc=0x40 and out_ready=1 in the same cycle → 0x40 is not accepted; in_rdy rises the next cycle.
- With 3 entries queued, pulse exe_flush for 1 cycle while in_valid=1 → out_valid=0 during the flush cycle; the next cycle count=0; the in-flight entry is not stored.
- Push 0x100, then 0x106 with in_misalign=1 → the 0x106 entry reads out with out_fault=1 and out_instr=0x00000013; in_rdy stays 0 after draining. An int_flush pulse returns in_rdy to 1.
- Assert rst low mid-stream with count=2 → count=0, out_valid=0, in_rdy=1 without a clock edge.
